// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store stage: RISC-V funct3 values, size codes,
// FSM state type and the alignment rule used on accept.
// No ports; imported by mem_access_unit and load_align.
package mem_access_pkg;

  // Load encodings (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store encodings (funct3)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Access size, funct3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // True when the access cannot be issued: address not naturally aligned for
  // its size, or a doubleword on a 32-bit datapath.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [2:0] low,
                                      input logic       is64);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = low[0];
      SZ_W:    bad = |low[1:0];
      default: bad = !is64 || (|low);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction: picks the addressed byte/half/word/double out of the
// response beat and sign- or zero-extends it to XLEN. Purely combinational.
// Ports: rdata (response beat), offset (byte offset in beat), funct3, data.
module load_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            rdata,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [2:0]                 funct3,
  output logic [XLEN-1:0]            data
);

  logic [XLEN-1:0] lane;

  // Move the addressed byte lane down to bit 0.
  assign lane = rdata >> {offset, 3'b000};

  // Extension is built at 64 bits and cast down so one expression covers
  // both datapath widths (a 32-bit word needs no extension at XLEN=32).
  always_comb begin
    data = lane;
    case (funct3)
      F3_LB:   data = XLEN'({{56{lane[7]}},  lane[7:0]});
      F3_LH:   data = XLEN'({{48{lane[15]}}, lane[15:0]});
      F3_LW:   data = XLEN'({{32{lane[31]}}, lane[31:0]});
      F3_LBU:  data = XLEN'({56'd0, lane[7:0]});
      F3_LHU:  data = XLEN'({48'd0, lane[15:0]});
      F3_LWU:  data = XLEN'({32'd0, lane[31:0]});
      F3_LD:   data = lane;
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: issues one aligned load/store request per operation or
// passes ALU results through; writeback is registered (1 cycle after accept
// for ALU/error, 1 cycle after handshake for stores, 1 cycle after response
// for loads). Backpressure: in_ready only in IDLE; request held until
// mem_req_ready; writeback has no backpressure.
// Ports: in_* operation from execute, mem_req_* / mem_rsp_* memory side,
// wb_* registered writeback, misalign_err one-cycle error pulse.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [4:0]          in_rd,
  input  logic [2:0]          in_funct3,
  input  logic                in_reg_write,
  input  logic                in_mem_read,
  input  logic                in_mem_write,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [XLEN-1:0]     mem_req_wdata,
  output logic [XLEN/8-1:0]   mem_req_be,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rsp_rdata,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                misalign_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  state_t          state;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [4:0]      rd_q;
  logic [2:0]      funct3_q;
  logic            reg_write_q;
  logic            we_q;

  logic            accept;
  logic            is_mem;
  logic            bad;
  logic [XLEN-1:0] addr_al;
  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] load_data;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mem   = in_mem_read | in_mem_write;
  assign bad      = misaligned(in_funct3[1:0], in_addr[2:0], XLEN == 64);

  // Request fields come only from the latched operation, so they cannot
  // move while the request waits for mem_req_ready.
  assign mem_req_valid = (state == ST_REQ);
  assign mem_req_we    = we_q;
  assign addr_al       = {addr_q[XLEN-1:OFS_W], {OFS_W{1'b0}}};
  assign mem_req_addr  = ADDR_W'(addr_al);
  assign mem_req_be    = size_mask << addr_q[OFS_W-1:0];

  always_comb begin
    size_mask = '1;
    case (funct3_q[1:0])
      SZ_B:    size_mask = NB'(1);
      SZ_H:    size_mask = NB'(3);
      SZ_W:    size_mask = NB'(15);
      default: size_mask = '1;
    endcase
  end

  // Replicate store data into every lane of its size so the byte enables
  // alone pick the destination bytes.
  always_comb begin
    mem_req_wdata = wdata_q;
    case ({1'b0, funct3_q[1:0]})
      F3_SB:   mem_req_wdata = {NB{wdata_q[7:0]}};
      F3_SH:   mem_req_wdata = {(NB/2){wdata_q[15:0]}};
      F3_SW:   mem_req_wdata = {(NB/4){wdata_q[31:0]}};
      F3_SD:   mem_req_wdata = wdata_q;
      default: mem_req_wdata = wdata_q;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (mem_rsp_rdata),
    .offset (addr_q[OFS_W-1:0]),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      funct3_q     <= '0;
      reg_write_q  <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= in_reg_write;
              wb_rd        <= in_rd;
              wb_data      <= in_addr;
            end else if (bad) begin
              wb_valid     <= 1'b1;
              wb_rd        <= in_rd;
              misalign_err <= 1'b1;
            end else begin
              addr_q      <= in_addr;
              wdata_q     <= in_wdata;
              rd_q        <= in_rd;
              funct3_q    <= in_funct3;
              reg_write_q <= in_reg_write;
              we_q        <= in_mem_write;  // both flags set -> store
              state       <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            if (we_q) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              state    <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= reg_write_q;
            wb_rd        <= rd_q;
            wb_data      <= load_data;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
